// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and constants for the decode/execute boundary
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int unsigned NOP_OP_DEFAULT = 0;

endpackage

`default_nettype wire

// File: rtl/pipe_payload_reg.sv
// ============================================================================
// pipe_payload_reg : one pipeline entry with load, clear-to-bubble, async reset
// Revision         : 1.0
// ============================================================================
`default_nettype none

module pipe_payload_reg #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // Clear wins over load so a squashed slot never captures fresh data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= CLR_VAL;
        end else if (clear_i) begin
            entry_q <= CLR_VAL;
        end else if (load_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

`default_nettype wire

// File: rtl/decode_execute_stage.sv
// ============================================================================
// decode_execute_stage : decode->execute register with 2-entry skid, flush
//                        and saturating stall-cycle counter
// Revision             : 1.0
// ============================================================================
`default_nettype none

module decode_execute_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned NOP_OP  = NOP_OP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_aluop,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_W-1:0]           out_aluop,
    output logic [NUM_SRC*DATA_W-1:0] out_src,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef struct packed {
        logic [OP_W-1:0]                 aluop;
        logic [NUM_SRC-1:0][DATA_W-1:0]  src;
    } payload_t;

    localparam int unsigned PAY_W       = $bits(payload_t);
    localparam payload_t    NOP_PAYLOAD = '{aluop: OP_W'(NOP_OP), src: '0};

    stage_state_t state_q, state_d;
    payload_t     in_payload, main_q, skid_q, main_d;
    logic         push, pop;
    logic         main_load, main_clear, skid_load, skid_clear;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_ready   = (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    assign in_payload.aluop = in_aluop;
    assign in_payload.src   = in_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        main_d     = in_payload;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = BUSY;
                        main_load = 1'b1;
                    end
                end
                BUSY: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                FULL: begin
                    // The skid entry is always the younger op, so it refills main.
                    if (pop) begin
                        state_d    = BUSY;
                        main_d     = skid_q;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_payload_reg #(
        .W       (PAY_W),
        .CLR_VAL (NOP_PAYLOAD)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear_i (main_clear),
        .load_i  (main_load),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_payload_reg #(
        .W       (PAY_W),
        .CLR_VAL (NOP_PAYLOAD)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .d_i     (in_payload),
        .q_o     (skid_q)
    );

    assign out_aluop = main_q.aluop;
    assign out_src   = main_q.src;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
